ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register directly downstream of the 32-bit ALU. Captures Result and the four ALU flags.
//  Resolves conditional branches from the flags and emits a one-cycle fetch redirect.
//  Buffers the result in a 2-entry skid buffer with valid/ready toward the memory stage.
// PARAMETERS
//  N      32  datapath width (Result, branch target)
//  RD_W   5   destination-register index width
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     asynchronous, active-high reset
//  in_valid       in   1     ALU output valid
//  in_ready       out  1     stage can accept (registered: !skid_full)
//  alu_result     in   N     ALU Result
//  f_negative     in   1     ALU negative flag
//  f_zero         in   1     ALU zero flag
//  f_carry        in   1     ALU carry flag (SUB: carry-out of A+~B+1, 1 = no borrow)
//  f_overflow     in   1     ALU signed overflow flag
//  branch_op      in   3     000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 none
//  branch_target  in   N     redirect PC for a taken branch
//  rd_in          in   RD_W  destination register
//  reg_write_in   in   1     writeback enable
//  flush          in   1     discard all buffered entries
//  out_valid      out  1     head entry valid
//  out_ready      in   1     memory stage accepts head
//  out_result     out  N     head Result
//  out_rd         out  RD_W  head destination register
//  out_reg_write  out  1     head writeback enable
//  redirect_valid out  1     one-cycle taken-branch pulse
//  redirect_pc    out  N     target accompanying redirect_valid
//  ovf_sticky     out  1     sticky overflow (see CONFIGURATION)
//  ovf_clear      in   1     clears ovf_sticky
// BEHAVIOUR
//  Reset (async, rst=1): every output is 0, and both entries are invalid.
//   Exception: in_ready=1 once rst deasserts. While rst=1, in_ready=0.
//  Accept: in_valid & in_ready at a rising edge. Latency is 1 cycle; an accepted entry is on out_* the next cycle when the head is empty.
//  Storage: head register plus skid register.
//   Accept while head is full and not draining: the entry goes to the skid.
//   Head drains (out_valid & out_ready): the skid moves to the head in that same edge.
//   Simultaneous accept and drain with the skid empty: the new entry becomes the head.
//   in_ready = !skid_valid, registered. It never depends combinationally on out_ready.
//  Full: with both entries valid, in_ready=0. in_valid is ignored, and no data is lost.
//  Empty: out_valid=0, out_* hold their last values, and out_reg_write is forced to 0.
//  Ordering: strict FIFO. There are no reorders and no duplicates.
//  Branch conditions are evaluated on the accepted entry (the ALU has executed SUB):
//   BEQ  taken = f_zero
//   BNE  taken = !f_zero
//   BLT  taken = f_negative ^ f_overflow
//   BGE  taken = !(f_negative ^ f_overflow)
//   BLTU taken = !f_carry
//   BGEU taken = f_carry
//  Redirect: redirect_valid=1 for exactly one cycle, the cycle after acceptance of a taken branch. redirect_pc = that entry's branch_target.
//   Branch entries still enter the buffer, with reg_write as supplied.
//  Flush: at the edge where flush=1, both entries are invalidated and any same-cycle input is dropped.
//   The next cycle has out_valid=0 and in_ready=1. A redirect pending from the prior edge still fires.
//  Reset mid-operation: buffered entries and any pending redirect are lost immediately.
// CONFIGURATION
//  EX_MEM_STICKY_OVF_EN defined:
//   ovf_sticky sets on any accepted entry with f_overflow=1 and branch_op=none, and holds until ovf_clear=1.
//   Set and clear in the same cycle: set wins.
//  EX_MEM_STICKY_OVF_EN undefined: ovf_sticky is tied to 0, ovf_clear is ignored, and no flop is inferred.
// TESTING
//  1 Reset pulse mid-stream with 2 entries held -> all outputs 0 immediately; in_ready=1 the cycle after rst falls.
//  2 Stream Result 0x80D000F0, 0x80D00040, 0xFFFFFFFE with out_ready=1 -> each appears 1 cycle after accept, in order, no bubbles.
//  3 out_ready=0, push 3 entries -> first 2 accepted, then in_ready=0.
//    Raise out_ready -> the 2 entries drain in order, and in_ready returns 1 after the first drain.
//  4 branch_op=BLT, f_negative=1, f_overflow=0, branch_target 0x00000100 -> redirect_valid 1 cycle later for 1 cycle, redirect_pc=0x100.
//    Same with BLTU and f_carry=1 -> no redirect.
//  5 Flush with 2 buffered entries and in_valid=1 -> next cycle out_valid=0, in_ready=1; the input is never output.
//  6 EX_MEM_STICKY_OVF_EN: ADD 0x7FFFFFFF+0x7FFFFFFF (f_overflow=1) -> ovf_sticky=1 until ovf_clear.
//    Undefined -> ovf_sticky stays 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: 2-entry skid buffer, branch resolution from ALU flags, fetch redirect.
// Optional sticky overflow flag enabled by defining EX_MEM_STICKY_OVF_EN.
module ex_mem_stage #(
    parameter int N    = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    alu_result,
    input  logic            f_negative,
    input  logic            f_zero,
    input  logic            f_carry,
    input  logic            f_overflow,
    input  logic [2:0]      branch_op,
    input  logic [N-1:0]    branch_target,
    input  logic [RD_W-1:0] rd_in,
    input  logic            reg_write_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            redirect_valid,
    output logic [N-1:0]    redirect_pc,
    output logic            ovf_sticky,
    input  logic            ovf_clear
);

    logic            head_valid_q, head_valid_d;
    logic [N-1:0]    head_result_q, head_result_d;
    logic [RD_W-1:0] head_rd_q, head_rd_d;
    logic            head_rw_q, head_rw_d;
    logic            skid_valid_q, skid_valid_d;
    logic [N-1:0]    skid_result_q, skid_result_d;
    logic [RD_W-1:0] skid_rd_q, skid_rd_d;
    logic            skid_rw_q, skid_rw_d;
    logic            in_ready_q, in_ready_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [N-1:0]    redirect_pc_q, redirect_pc_d;
    logic            accept, drain, taken;

    // A flushed cycle accepts nothing, so a dropped branch cannot redirect either.
    assign accept = in_valid & in_ready_q & ~flush;
    assign drain  = head_valid_q & out_ready;

    always_comb begin
        taken = 1'b0;
        case (branch_op)
            3'b001:  taken = f_zero;
            3'b010:  taken = ~f_zero;
            3'b011:  taken = f_negative ^ f_overflow;
            3'b100:  taken = ~(f_negative ^ f_overflow);
            3'b101:  taken = ~f_carry;
            3'b110:  taken = f_carry;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        head_valid_d  = head_valid_q & ~drain;
        head_result_d = head_result_q;
        head_rd_d     = head_rd_q;
        head_rw_d     = head_rw_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;
        skid_rw_d     = skid_rw_q;
        if (drain && skid_valid_q) begin
            head_valid_d  = 1'b1;
            head_result_d = skid_result_q;
            head_rd_d     = skid_rd_q;
            head_rw_d     = skid_rw_q;
            skid_valid_d  = 1'b0;
        end
        // Accept implies the skid is empty, since in_ready mirrors !skid_valid.
        if (accept) begin
            if (!head_valid_q || drain) begin
                head_valid_d  = 1'b1;
                head_result_d = alu_result;
                head_rd_d     = rd_in;
                head_rw_d     = reg_write_in;
            end else begin
                skid_valid_d  = 1'b1;
                skid_result_d = alu_result;
                skid_rd_d     = rd_in;
                skid_rw_d     = reg_write_in;
            end
        end
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
        in_ready_d       = ~skid_valid_d;
        redirect_valid_d = accept & taken;
        redirect_pc_d    = (accept && taken) ? branch_target : redirect_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q     <= 1'b0;
            head_result_q    <= '0;
            head_rd_q        <= '0;
            head_rw_q        <= 1'b0;
            skid_valid_q     <= 1'b0;
            skid_result_q    <= '0;
            skid_rd_q        <= '0;
            skid_rw_q        <= 1'b0;
            in_ready_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            head_valid_q     <= head_valid_d;
            head_result_q    <= head_result_d;
            head_rd_q        <= head_rd_d;
            head_rw_q        <= head_rw_d;
            skid_valid_q     <= skid_valid_d;
            skid_result_q    <= skid_result_d;
            skid_rd_q        <= skid_rd_d;
            skid_rw_q        <= skid_rw_d;
            in_ready_q       <= in_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = head_valid_q;
    assign out_result     = head_result_q;
    assign out_rd         = head_rd_q;
    assign out_reg_write  = head_valid_q & head_rw_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef EX_MEM_STICKY_OVF_EN
    logic ovf_sticky_q, ovf_sticky_d;

    // Only non-branch entries count; a set in the same cycle as a clear wins.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (ovf_clear)
            ovf_sticky_d = 1'b0;
        if (accept && f_overflow && (branch_op == 3'b000 || branch_op == 3'b111))
            ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_sticky_q <= 1'b0;
        else
            ovf_sticky_q <= ovf_sticky_d;
    end

    assign ovf_sticky = ovf_sticky_q;
`else
    logic ovf_unused;
    assign ovf_unused = &{1'b0, ovf_clear};
    assign ovf_sticky = 1'b0;
`endif

endmodule
